wash_controller: RTL

WASH_CONTROLLER -- requirements
Module: wash_controller

---
 rtl/wm_pkg.sv | 27 ++
 rtl/wash_controller.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/wm_pkg.sv
// Shared state encoding and default phase durations for the wash controller.
package wm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_WASH  = 3'd2,
        ST_RINSE = 3'd3,
        ST_SPIN  = 3'd4,
        ST_DRY   = 3'd5
    } state_t;

    localparam logic [15:0] FILL_TIME_DEF  = 16'd2;
    localparam logic [15:0] WASH_TIME_DEF  = 16'd5;
    localparam logic [15:0] RINSE_TIME_DEF = 16'd2;
    localparam logic [15:0] SPIN_TIME_DEF  = 16'd1;
    localparam logic [15:0] DRY_TIME_DEF   = 16'd3;

    // timer_done is stale for the entry cycle and the one after it.
    localparam logic [1:0] QUAL_AGE = 2'd2;

    // Phases that a user pause may freeze; spin keeps going through a pause.
    function automatic logic pause_sensitive(state_t s);
        return (s != ST_IDLE) && (s != ST_SPIN);
    endfunction

endpackage

// File: rtl/wash_controller.sv
// Washing-machine programme sequencer; optional dry phase enabled by macro DRY_CYCLE_EN.
// Latency: state advances one cycle after coin or qualified timer_done; outputs decode state_q.
// Backpressure: pause/open door freezes the phase and drops timer_en; resume skips timer_clr.
module wash_controller
    import wm_pkg::*;
#(
    parameter logic [15:0] FILL_TIME  = FILL_TIME_DEF,
    parameter logic [15:0] WASH_TIME  = WASH_TIME_DEF,
    parameter logic [15:0] RINSE_TIME = RINSE_TIME_DEF,
    parameter logic [15:0] SPIN_TIME  = SPIN_TIME_DEF,
    parameter logic [15:0] DRY_TIME   = DRY_TIME_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        coin_in,
    input  logic        double_wash,
    input  logic        door_closed,
    input  logic        pause,
    input  logic        timer_done,
    output logic [15:0] timer_period,
    output logic        timer_en,
    output logic        timer_clr,
    output logic        water_valve,
    output logic        motor_on,
    output logic        spin_fast,
    output logic        drain,
    output logic        heater,
    output logic        door_lock,
    output logic        cycle_done,
    output logic [2:0]  state
);

    state_t     state_q, state_d;
    logic       dw_pending_q, dw_pending_d;
    logic [1:0] age_q, age_d;
    logic       cycle_done_q, cycle_done_d;

    logic timed;
    logic entry;
    logic hold;
    logic advance;

    always_comb begin
        timed   = (state_q != ST_IDLE);
        entry   = timed && (age_q == 2'd0);
        hold    = timed && (!door_closed || (pause && pause_sensitive(state_q)));
        // A qualified done beats a same-cycle pause, but an open door still holds.
        advance = timed && timer_done && (age_q == QUAL_AGE) && door_closed;
    end

    always_comb begin
        state_d      = state_q;
        dw_pending_d = dw_pending_q;
        cycle_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (coin_in && door_closed) begin
                    state_d      = ST_FILL;
                    dw_pending_d = double_wash;
                end
            end
            ST_FILL: begin
                if (advance) state_d = ST_WASH;
            end
            ST_WASH: begin
                if (advance) state_d = ST_RINSE;
            end
            ST_RINSE: begin
                if (advance) begin
                    if (dw_pending_q) begin
                        state_d      = ST_WASH;
                        dw_pending_d = 1'b0;
                    end else begin
                        state_d = ST_SPIN;
                    end
                end
            end
            ST_SPIN: begin
                if (advance) begin
`ifdef DRY_CYCLE_EN
                    state_d = ST_DRY;
`else
                    state_d      = ST_IDLE;
                    cycle_done_d = 1'b1;
`endif
                end
            end
`ifdef DRY_CYCLE_EN
            ST_DRY: begin
                if (advance) begin
                    state_d      = ST_IDLE;
                    cycle_done_d = 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q) begin
            age_d = 2'd0;
        end else if (age_q == QUAL_AGE) begin
            age_d = age_q;
        end else begin
            age_d = age_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            dw_pending_q <= 1'b0;
            age_q        <= 2'd0;
            cycle_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dw_pending_q <= dw_pending_d;
            age_q        <= age_d;
            cycle_done_q <= cycle_done_d;
        end
    end

    always_comb begin
        water_valve  = 1'b0;
        motor_on     = 1'b0;
        spin_fast    = 1'b0;
        drain        = 1'b0;
        heater       = 1'b0;
        door_lock    = 1'b0;
        cycle_done   = 1'b0;
        timer_period = 16'd0;
        timer_en     = 1'b0;
        timer_clr    = 1'b0;
        if (reset) begin
            // Clear the external timer even if reset lands mid-programme.
            timer_en  = 1'b1;
            timer_clr = 1'b1;
        end else begin
            cycle_done = cycle_done_q;
            door_lock  = timed;
            timer_clr  = entry;
            timer_en   = entry || (timed && !hold);
            case (state_q)
                ST_FILL: begin
                    timer_period = FILL_TIME;
                    water_valve  = !hold;
                end
                ST_WASH: begin
                    timer_period = WASH_TIME;
                    motor_on     = !hold;
                end
                ST_RINSE: begin
                    timer_period = RINSE_TIME;
                    water_valve  = !hold;
                    motor_on     = !hold;
                end
                ST_SPIN: begin
                    timer_period = SPIN_TIME;
                    motor_on     = !hold;
                    spin_fast    = !hold;
                    drain        = 1'b1;
                end
`ifdef DRY_CYCLE_EN
                ST_DRY: begin
                    timer_period = DRY_TIME;
                    motor_on     = !hold;
                    heater       = !hold;
                end
`endif
                default: ;
            endcase
        end
    end

`ifndef DRY_CYCLE_EN
    logic unused_dry_time;
    assign unused_dry_time = ^DRY_TIME;
`endif

    assign state = state_q;

endmodule
